// File: rtl/bias_relu_stage_layer1_pkg.sv
// Shared definitions for the layer-1 bias + ReLU stage.
//   - FSM state codes (2-bit) and the typed state enum built on them.
//   - Default element widths and fixed-point shifts.
//   - sat_max(): largest positive value of a w-bit two's complement number.
package layer1_pkg;

  localparam int unsigned DefW         = 8;
  localparam int unsigned DefAccW      = 20;
  localparam int unsigned DefBiasShift = 4;
  localparam int unsigned DefOutShift  = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StWait = WAIT,
    StRun  = RUN,
    StDone = DONE
  } state_e;

  function automatic int unsigned sat_max(int unsigned w);
    return (32'd1 << (w - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bias_relu_stage_layer1_if.sv
// Handshake/data bundle between the layer-1 producers (bias loader, MAC array)
// and the bias + ReLU stage.
//   start      : begin a new pass
//   bias_in    : packed biases, element i at [i*W +: W]
//   bias_done  : loader done level, bias_in valid while high
//   acc_in     : packed accumulators, element i at [i*ACC_W +: ACC_W]
//   acc_valid  : acc_in valid this cycle
//   data_out   : packed activations for layer 2
//   busy/done  : stage status
// master drives the inputs of the stage; slave is the stage itself.
interface bias_relu_stage_layer1_if
  import layer1_pkg::*;
#(
  parameter int unsigned OUT_SIZE = 8,
  parameter int unsigned W        = DefW,
  parameter int unsigned ACC_W    = DefAccW
);

  logic                      start;
  logic [OUT_SIZE*W-1:0]     bias_in;
  logic                      bias_done;
  logic [OUT_SIZE*ACC_W-1:0] acc_in;
  logic                      acc_valid;
  logic [OUT_SIZE*W-1:0]     data_out;
  logic                      busy;
  logic                      done;

  modport master (
    output start, bias_in, bias_done, acc_in, acc_valid,
    input  data_out, busy, done
  );

  modport slave (
    input  start, bias_in, bias_done, acc_in, acc_valid,
    output data_out, busy, done
  );

endinterface

// File: rtl/bias_relu_stage_layer1_sat.sv
// bias_relu_sat: combinational per-neuron datapath.
//   acc_i : ACC_W-bit signed accumulator
//   bias_i: W-bit signed bias
//   y_o   : W-bit activation, clamp(relu(acc + (bias << BIAS_SHIFT)) >>> OUT_SHIFT)
// Optional macro BIAS_RELU_ROUND_EN: round half up before the output shift.
module bias_relu_sat
  import layer1_pkg::*;
#(
  parameter int unsigned W          = DefW,
  parameter int unsigned ACC_W      = DefAccW,
  parameter int unsigned BIAS_SHIFT = DefBiasShift,
  parameter int unsigned OUT_SHIFT  = DefOutShift
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [W-1:0]     bias_i,
  output logic [W-1:0]     y_o
);

  // Two guard bits keep acc + aligned bias (+ rounding) from wrapping.
  localparam int unsigned SW = ACC_W + 2;
  localparam logic signed [SW-1:0] SatMax = SW'(sat_max(W));
`ifdef BIAS_RELU_ROUND_EN
  localparam logic signed [SW-1:0] RoundAdd = SW'((OUT_SHIFT == 0) ? 0 : (2 ** OUT_SHIFT) / 2);
`endif

  logic signed [SW-1:0] acc_ext;
  logic signed [SW-1:0] bias_ext;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] relu;
  logic signed [SW-1:0] pre;
  logic signed [SW-1:0] shr;

  always_comb begin
    acc_ext  = {{(SW - ACC_W){acc_i[ACC_W-1]}}, acc_i};
    bias_ext = {{(SW - W){bias_i[W-1]}}, bias_i};
    bias_ext = bias_ext <<< BIAS_SHIFT;
    sum      = acc_ext + bias_ext;
    relu     = sum[SW-1] ? '0 : sum;
`ifdef BIAS_RELU_ROUND_EN
    pre      = relu + RoundAdd;
`else
    pre      = relu;
`endif
    shr      = pre >>> OUT_SHIFT;
    // shr is never negative, so only the upper bound needs clamping.
    y_o      = (shr > SatMax) ? SatMax[W-1:0] : shr[W-1:0];
  end

endmodule

// File: rtl/bias_relu_stage_layer1.sv
// Layer-1 bias + ReLU stage. Snapshots the loader's bias vector and the MAC
// accumulator vector, then produces one saturated activation per cycle into a
// packed output register for layer 2.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus_if     : slave side of bias_relu_stage_layer1_if (start, bias_in,
//                bias_done, acc_in, acc_valid in; data_out, busy, done out)
// Optional macro BIAS_RELU_ROUND_EN (see bias_relu_sat): round half up.
module bias_relu_stage_layer1
  import layer1_pkg::*;
#(
  parameter int unsigned OUT_SIZE   = 8,
  parameter int unsigned W          = DefW,
  parameter int unsigned ACC_W      = DefAccW,
  parameter int unsigned BIAS_SHIFT = DefBiasShift,
  parameter int unsigned OUT_SHIFT  = DefOutShift,
  parameter int unsigned IDX_W      = 4
) (
  input logic clk,
  input logic rst_n,
  bias_relu_stage_layer1_if.slave bus_if
);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [OUT_SIZE*W-1:0]     bias_q, bias_d;
  logic [OUT_SIZE*ACC_W-1:0] acc_q, acc_d;
  logic [OUT_SIZE*W-1:0]     data_q, data_d;
  logic                      bias_seen_q, bias_seen_d;
  logic                      acc_seen_q, acc_seen_d;

  logic [ACC_W-1:0]          cur_acc;
  logic [W-1:0]              cur_bias;
  logic [W-1:0]              cur_y;

  // Select the snapshot element addressed by idx_q.
  always_comb begin
    cur_acc  = '0;
    cur_bias = '0;
    for (int i = 0; i < OUT_SIZE; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_acc  = acc_q[i*ACC_W +: ACC_W];
        cur_bias = bias_q[i*W +: W];
      end
    end
  end

  bias_relu_sat #(
    .W          (W),
    .ACC_W      (ACC_W),
    .BIAS_SHIFT (BIAS_SHIFT),
    .OUT_SHIFT  (OUT_SHIFT)
  ) u_sat (
    .acc_i  (cur_acc),
    .bias_i (cur_bias),
    .y_o    (cur_y)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    bias_d      = bias_q;
    acc_d       = acc_q;
    data_d      = data_q;
    bias_seen_d = bias_seen_q;
    acc_seen_d  = acc_seen_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus_if.start) begin
          state_d     = StWait;
          bias_seen_d = 1'b0;
          acc_seen_d  = 1'b0;
        end
      end
      StWait: begin
        if (bus_if.bias_done) begin
          bias_d      = bus_if.bias_in;
          bias_seen_d = 1'b1;
        end
        if (bus_if.acc_valid) begin
          acc_d      = bus_if.acc_in;
          acc_seen_d = 1'b1;
        end
        // Uses next-state flags so both arriving in one cycle exits at once.
        if (bias_seen_d && acc_seen_d) begin
          state_d = StRun;
          idx_d   = '0;
        end
      end
      StRun: begin
        for (int i = 0; i < OUT_SIZE; i++) begin
          if (idx_q == IDX_W'(i)) begin
            data_d[i*W +: W] = cur_y;
          end
        end
        if (idx_q == IDX_W'(OUT_SIZE - 1)) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      bias_q      <= '0;
      acc_q       <= '0;
      data_q      <= '0;
      bias_seen_q <= 1'b0;
      acc_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      bias_q      <= bias_d;
      acc_q       <= acc_d;
      data_q      <= data_d;
      bias_seen_q <= bias_seen_d;
      acc_seen_q  <= acc_seen_d;
    end
  end

  assign bus_if.data_out = data_q;
  assign bus_if.busy     = (state_q == StWait) || (state_q == StRun);
  assign bus_if.done     = (state_q == StDone);

endmodule

// File: tb/tb_bias_relu_stage_layer1.sv
// Self-checking bench for bias_relu_stage_layer1 (OUT_SIZE=8, W=8, ACC_W=20,
// BIAS_SHIFT=4, OUT_SHIFT=4). Expected elements are queued when a pass is
// loaded and popped as the DUT writes each element.
module tb_bias_relu_stage_layer1;

  localparam int unsigned N = 8;

  typedef struct packed {
    logic [N-1:0][19:0] acc;
    logic [N-1:0][7:0]  bias;
    logic [N-1:0][7:0]  exp;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   wr_idx  = 0;
  logic [7:0]        sb[$];
  logic [N-1:0][7:0] model;
  vec_t              vecs[3];

  always #5 clk = ~clk;

  bias_relu_stage_layer1_if #(.OUT_SIZE(N), .W(8), .ACC_W(20)) bus_if ();

  bias_relu_stage_layer1 #(
    .OUT_SIZE   (N),
    .W          (8),
    .ACC_W      (20),
    .BIAS_SHIFT (4),
    .OUT_SHIFT  (4),
    .IDX_W      (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus_if.slave)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, got, want);
    end
  endtask

  task automatic start_pass();
    @(negedge clk);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    check_bit("busy_after_start", bus_if.busy, 1'b1);
    check_bit("done_after_start", bus_if.done, 1'b0);
    check("data_held_at_start", bus_if.data_out, model);
  endtask

  task automatic push_exp(input vec_t v);
    for (int k = 0; k < N; k++) sb.push_back(v.exp[k]);
    wr_idx = 0;
  endtask

  // Both inputs valid in the same cycle; returns just after the WAIT exit edge.
  task automatic load_both(input vec_t v);
    bus_if.bias_in   = v.bias;
    bus_if.acc_in    = v.acc;
    bus_if.bias_done = 1'b1;
    bus_if.acc_valid = 1'b1;
    push_exp(v);
    @(negedge clk);
    bus_if.bias_done = 1'b0;
    bus_if.acc_valid = 1'b0;
    check("data_no_write_at_exit", bus_if.data_out, model);
  endtask

  // Observe n element writes; with noise, drive ignored inputs during RUN.
  task automatic drain(input int n, input bit noise);
    for (int k = 0; k < n; k++) begin
      if (noise && k == 2) begin
        bus_if.start     = 1'b1;
        bus_if.acc_valid = 1'b1;
        bus_if.acc_in    = '1;
        bus_if.bias_done = 1'b1;
        bus_if.bias_in   = {N{8'h7f}};
      end
      @(negedge clk);
      bus_if.start     = 1'b0;
      bus_if.acc_valid = 1'b0;
      bus_if.bias_done = 1'b0;
      if (sb.size() == 0 || wr_idx >= N) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got empty queue required element %0d", wr_idx);
      end else begin
        model[wr_idx] = sb.pop_front();
        wr_idx++;
        check($sformatf("data_elem%0d", wr_idx - 1), bus_if.data_out, model);
        check_bit($sformatf("done_elem%0d", wr_idx - 1), bus_if.done, wr_idx == N);
        check_bit($sformatf("busy_elem%0d", wr_idx - 1), bus_if.busy, wr_idx != N);
      end
    end
  endtask

  task automatic hold_check();
    @(negedge clk);
    check_bit("done_held", bus_if.done, 1'b1);
    check("data_held", bus_if.data_out, model);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    bus_if.start     = 1'b0;
    bus_if.bias_in   = '0;
    bus_if.bias_done = 1'b0;
    bus_if.acc_in    = '0;
    bus_if.acc_valid = 1'b0;
    model            = '0;

    for (int i = 0; i < N; i++) begin
      vecs[0].acc[i]  = 20'd160;
      vecs[0].bias[i] = 8'd2;
      vecs[0].exp[i]  = 8'd12;
      vecs[1].acc[i]  = 20'd160;
      vecs[1].bias[i] = 8'd2;
      vecs[1].exp[i]  = 8'd12;
      vecs[2].acc[i]  = 20'(i * 100);
      vecs[2].bias[i] = 8'(-i);
    end
    vecs[1].acc[0] = 20'd4000;     vecs[1].bias[0] = 8'd0;    vecs[1].exp[0] = 8'd127;
    vecs[1].acc[1] = 20'h80000;    vecs[1].bias[1] = 8'h80;   vecs[1].exp[1] = 8'd0;
    vecs[1].acc[3] = 20'(-100);    vecs[1].bias[3] = 8'd1;    vecs[1].exp[3] = 8'd0;
    vecs[1].acc[5] = 20'(-32);     vecs[1].bias[5] = 8'd2;    vecs[1].exp[5] = 8'd0;
    vecs[1].acc[7] = 20'h7ffff;    vecs[1].bias[7] = 8'd127;  vecs[1].exp[7] = 8'd127;
    vecs[1].acc[2] = 20'd24;       vecs[1].bias[2] = 8'd0;
    vecs[1].acc[4] = 20'd15;       vecs[1].bias[4] = 8'd0;
    vecs[1].acc[6] = 20'd2031;     vecs[1].bias[6] = 8'd0;
`ifdef BIAS_RELU_ROUND_EN
    vecs[1].exp[2] = 8'd2;
    vecs[1].exp[4] = 8'd1;
    vecs[1].exp[6] = 8'd127;
    vecs[2].exp = {8'd37, 8'd32, 8'd26, 8'd21, 8'd16, 8'd11, 8'd5, 8'd0};
`else
    vecs[1].exp[2] = 8'd1;
    vecs[1].exp[4] = 8'd0;
    vecs[1].exp[6] = 8'd126;
    vecs[2].exp = {8'd36, 8'd31, 8'd26, 8'd21, 8'd15, 8'd10, 8'd5, 8'd0};
`endif

    // Reset state.
    #12;
    check("reset_data", bus_if.data_out, 64'd0);
    check_bit("reset_busy", bus_if.busy, 1'b0);
    check_bit("reset_done", bus_if.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven passes, both inputs arriving in the same cycle.
    for (int v = 0; v < 3; v++) begin
      start_pass();
      load_both(vecs[v]);
      drain(N, 1'b0);
      hold_check();
    end

    // Ordering: bias alone for 5 cycles (last capture wins), then an acc pulse.
    start_pass();
    for (int c = 0; c < 5; c++) begin
      bus_if.bias_done = 1'b1;
      bus_if.bias_in   = (c == 4) ? vecs[0].bias : {N{8'h7f}};
      @(negedge clk);
      check_bit("wait_busy", bus_if.busy, 1'b1);
      check_bit("wait_done", bus_if.done, 1'b0);
      check("wait_no_write", bus_if.data_out, model);
    end
    bus_if.bias_done = 1'b0;
    bus_if.bias_in   = '0;
    bus_if.acc_in    = vecs[0].acc;
    bus_if.acc_valid = 1'b1;
    push_exp(vecs[0]);
    @(negedge clk);
    bus_if.acc_valid = 1'b0;
    bus_if.acc_in    = '0;
    drain(N, 1'b1);
    hold_check();

    // Reset mid-RUN at idx=4, then a clean restart.
    start_pass();
    load_both(vecs[1]);
    drain(4, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_data", bus_if.data_out, 64'd0);
    check_bit("midrst_busy", bus_if.busy, 1'b0);
    check_bit("midrst_done", bus_if.done, 1'b0);
    sb.delete();
    model = '0;
    @(negedge clk);
    rst_n = 1'b1;
    check_bit("idle_after_rst", bus_if.busy, 1'b0);
    start_pass();
    load_both(vecs[2]);
    drain(N, 1'b0);
    hold_check();

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bias_relu_stage_layer1.md
Name: bias_relu_stage_layer1

Overview:
- Downstream consumer of the layer-1 bias loader.
- Takes the loader's packed bias vector and the layer-1 MAC accumulator vector.
- Per neuron: adds the aligned bias, applies ReLU, rescales and saturates to W-bit signed.
- Publishes the packed activation vector for layer 2, one neuron per cycle, with a start/done handshake matching the loader's.

Parameters:
- OUT_SIZE, 8: neurons in layer 1; equals the loader's TOTAL_WEIGHTS for a 1-input layer.
- W, 8: bias and output element width, two's complement.
- ACC_W, 20: accumulator element width, two's complement.
- BIAS_SHIFT, 4: left shift aligning bias fixed point to accumulator fixed point.
- OUT_SHIFT, 4: arithmetic right shift from accumulator scale to output scale.
- IDX_W, 4: neuron index width; must satisfy 2^IDX_W >= OUT_SIZE.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: begin a new pass; honoured in IDLE and DONE only.
- bias_in, input, OUT_SIZE*W: packed biases; element i at [i*W +: W].
- bias_done, input, 1: loader done level; bias_in valid while high.
- acc_in, input, OUT_SIZE*ACC_W: packed accumulators; element i at [i*ACC_W +: ACC_W].
- acc_valid, input, 1: acc_in valid this cycle; may be a pulse or a level.
- data_out, output, OUT_SIZE*W: packed activations, registered.
- busy, output, 1: high in WAIT and RUN.
- done, output, 1: high in DONE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; data_out=0, busy=0, done=0.
  - Index, snapshot registers and ready flags cleared.
  - Reset mid-pass abandons the pass; no partial data is retained.
- States: IDLE, WAIT, RUN, DONE (2-bit encoding).
- IDLE: start=1 -> WAIT; clear bias_seen and acc_seen.
- WAIT:
  - Snapshot independently as each input arrives:
    - bias_done=1 -> capture bias_in into bias_q, set bias_seen.
    - acc_valid=1 -> capture acc_in into acc_q, set acc_seen.
  - Re-captures while still in WAIT overwrite (last value wins).
  - Leave WAIT at the edge where both flags are, or become, set, including both arriving in the same cycle -> RUN, idx=0.
  - start is ignored.
- RUN:
  - Each cycle compute element idx and write data_out[idx*W +: W]; idx increments.
  - After writing idx=OUT_SIZE-1 -> DONE.
  - start, bias_done and acc_valid are ignored.
- DONE:
  - done=1; data_out held stable.
  - start=1 -> WAIT, done drops next cycle.
  - data_out keeps old values until overwritten element by element.
- Latency: T = edge at which WAIT exits. Elements are written at edges T+1..T+OUT_SIZE; done is visible after edge T+OUT_SIZE.
- Per-element arithmetic, in ACC_W+2 bits signed:
  - s = sext(acc_q[i]) + (sext(bias_q[i]) << BIAS_SHIFT).
  - ReLU: s<0 -> 0.
  - r = s >>> OUT_SHIFT.
  - Saturate: r > 2^(W-1)-1 -> 2^(W-1)-1 (127 at W=8).
  - Output is never negative.
- Overflow: the extended sum width guarantees no wrap before saturation.

Optional Feature:
- Macro: BIAS_RELU_ROUND_EN.
- Defined: after ReLU and before the shift, add 2^(OUT_SHIFT-1), i.e. round half up. No effect when OUT_SHIFT=0. Saturation is still applied after the shift.
- Undefined: plain truncating shift.
- Latency and handshake are identical in both builds.

Decomposition:
- Package layer1_pkg holds:
  - state localparams IDLE/WAIT/RUN/DONE;
  - default W, ACC_W, BIAS_SHIFT, OUT_SHIFT;
  - function sat_max(W)=2^(W-1)-1.
- Sub-module bias_relu_sat: purely combinational per-neuron datapath.
  - Inputs: acc (ACC_W), bias (W). Output: y (W).
  - Contains the rounding ifdef.
  - Top level holds the FSM, snapshots, index and output registers.

Test Plan (W=8, ACC_W=20, BIAS_SHIFT=4, OUT_SHIFT=4, OUT_SIZE=8):
- Basic pass: acc[i]=160, bias[i]=2 for all i; start, then both ready in the same cycle -> every element = (160+32)>>4 = 12; done exactly 8 edges after the WAIT exit edge.
- Negative: acc[3]=-100, bias[3]=1 (sum -84) -> element 3 = 0; others unaffected.
- Saturation: acc[0]=4000, bias[0]=0 -> 127. Also acc[1]=-524288 with bias[1]=-128 -> 0, with no wrap.
- Rounding: acc=24, bias=0 -> 1 without the macro; 2 with BIAS_RELU_ROUND_EN.
- Ordering: bias_done held high 5 cycles before a 1-cycle acc_valid pulse -> RUN entered at the pulse edge. A second acc_valid pulse during RUN is ignored. start during RUN is ignored.
- Reset mid-RUN: rst_n low at idx=4 -> data_out=0, busy=0, done=0 immediately. A restart then completes normally in OUT_SIZE cycles.
